// File: rtl/bsg_link_ddr_downstream_core.sv
// rtl/bsg_link_ddr_downstream_core.sv - DDR link core-side receive: per-channel FIFOs, deskew, packet reassembly, credit tokens (optional macro: BSG_LINK_DOWNSTREAM_OVERFLOW_CHECK_EN)
module bsg_link_ddr_downstream_core #(
    parameter int width_p                         = 64,
    parameter int channel_width_p                 = 8,
    parameter int num_channels_p                  = 2,
    parameter int lg_fifo_depth_p                 = 6,
    parameter int lg_credit_to_token_decimation_p = 3,
    parameter int use_extra_data_bit_p            = 0
) (
    input  logic                                                 clk_i,
    input  logic                                                 reset_n_i,
    input  logic [num_channels_p-1:0]                            ch_valid_i,
    input  logic [num_channels_p*(2*channel_width_p+use_extra_data_bit_p)-1:0] ch_data_i,
    output logic                                                 valid_o,
    output logic [width_p-1:0]                                   data_o,
    input  logic                                                 yumi_i,
    output logic [num_channels_p-1:0]                            token_r_o,
    output logic                                                 overflow_o
);

    localparam int ddr_width_lp   = 2*channel_width_p + use_extra_data_bit_p;
    localparam int beat_width_lp  = ddr_width_lp*num_channels_p;
    localparam int piso_ratio_lp  = width_p / beat_width_lp;
    localparam int fifo_depth_lp  = 1 << lg_fifo_depth_p;
    localparam int count_width_lp = $clog2(piso_ratio_lp+1);
    localparam logic [count_width_lp-1:0] piso_count_lp = count_width_lp'(piso_ratio_lp);

    logic [num_channels_p-1:0] w_full;
    logic [num_channels_p-1:0] w_empty;
    logic [num_channels_p-1:0] w_write;
    logic [beat_width_lp-1:0]  w_beat;
    logic                      w_take;
    logic                      w_space;
    logic                      w_pop;
    logic [count_width_lp-1:0] w_slot;
    logic [count_width_lp-1:0] w_count_next;

    logic [count_width_lp-1:0] r_count;
    logic                      r_valid;
    logic [width_p-1:0]        r_data;
    logic [lg_credit_to_token_decimation_p-1:0] r_credit;
    logic [num_channels_p-1:0] r_token;

    // Per-channel circular FIFO; extra pointer MSB separates full from empty
    for (genvar i = 0; i < num_channels_p; i++) begin : g_ch
        logic [ddr_width_lp-1:0]  r_mem [fifo_depth_lp];
        logic [lg_fifo_depth_p:0] r_wptr;
        logic [lg_fifo_depth_p:0] r_rptr;

        assign w_full[i]  = (r_wptr[lg_fifo_depth_p] != r_rptr[lg_fifo_depth_p]) &&
                            (r_wptr[lg_fifo_depth_p-1:0] == r_rptr[lg_fifo_depth_p-1:0]);
        assign w_empty[i] = (r_wptr == r_rptr);
        assign w_write[i] = ch_valid_i[i] & ~w_full[i];
        assign w_beat[i*ddr_width_lp +: ddr_width_lp] = r_mem[r_rptr[lg_fifo_depth_p-1:0]];

        // Storage array: written only when there is room, so a word into a full FIFO is dropped
        always_ff @(posedge clk_i) begin
            if (w_write[i]) begin
                r_mem[r_wptr[lg_fifo_depth_p-1:0]] <= ch_data_i[i*ddr_width_lp +: ddr_width_lp];
            end
        end

        // Pointers: reset empties the FIFO, discarding any partially received packet
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_write[i]) r_wptr <= r_wptr + 1'b1;
                if (w_pop)      r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // A packet handed to the consumer frees the whole buffer this cycle
    assign w_take  = yumi_i & r_valid;
    assign w_space = (r_count < piso_count_lp) | w_take;
    assign w_pop   = ~(|w_empty) & w_space;

    // Next slot/count: a pop that coincides with a take restarts at slot 0
    always_comb begin
        w_slot       = r_count;
        w_count_next = r_count;
        if (w_take) begin
            w_slot       = '0;
            w_count_next = '0;
        end
        if (w_pop) begin
            w_count_next = w_slot + 1'b1;
        end
    end

    // Reassembly buffer: each popped beat lands in its slot, beat 0 in the LSBs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (w_pop) begin
                for (int k = 0; k < piso_ratio_lp; k++) begin
                    if (w_slot == count_width_lp'(k)) begin
                        r_data[k*beat_width_lp +: beat_width_lp] <= w_beat;
                    end
                end
            end
            r_count <= w_count_next;
            r_valid <= (w_count_next == piso_count_lp);
        end
    end

    // Credit decimation: every wrap of the shared counter toggles all token lines
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_credit <= '0;
            r_token  <= '0;
        end else if (w_pop) begin
            r_credit <= r_credit + 1'b1;
            if (&r_credit) begin
                r_token <= ~r_token;
            end
        end
    end

    assign valid_o   = r_valid;
    assign data_o    = r_data;
    assign token_r_o = r_token;

`ifdef BSG_LINK_DOWNSTREAM_OVERFLOW_CHECK_EN
    logic r_overflow;

    // Sticky flag: any write attempt into a full FIFO is a sender protocol error
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_overflow <= 1'b0;
        end else if (|(ch_valid_i & w_full)) begin
            r_overflow <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Report which channel overflowed
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            for (int i = 0; i < num_channels_p; i++) begin
                if (ch_valid_i[i] && w_full[i]) begin
                    $error("bsg_link_ddr_downstream_core: overflow on channel %0d", i);
                end
            end
        end
    end
`endif

    assign overflow_o = r_overflow;
`else
    assign overflow_o = 1'b0;
`endif

endmodule
